// File: rtl/axi_slave_mem.sv
// AXI3 slave memory, FIXED/INCR/WRAP bursts, byte strobes; AXI_SLV_ERR_EN adds SLVERR on bad size/range.
// Latency: first R beat 1 cycle after AR, bvalid 1 cycle after the last W beat; beats stream with no bubble.
// Backpressure: readies decode from FSM state; R outputs hold while rvalid & !rready, B holds until bready.
module axi_slave_mem #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int LEN_WIDTH  = 4,
  parameter int MEM_DEPTH  = 256
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [ID_WIDTH-1:0]     awid,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [LEN_WIDTH-1:0]    awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic                    wvalid,
  output logic                    wready,
  input  logic [ID_WIDTH-1:0]     wid,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  output logic                    bvalid,
  input  logic                    bready,
  output logic [ID_WIDTH-1:0]     bid,
  output logic [1:0]              bresp,
  input  logic                    arvalid,
  output logic                    arready,
  input  logic [ID_WIDTH-1:0]     arid,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [LEN_WIDTH-1:0]    arlen,
  input  logic [2:0]              arsize,
  input  logic [1:0]              arburst,
  output logic                    rvalid,
  input  logic                    rready,
  output logic [ID_WIDTH-1:0]     rid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int LG_STRB    = $clog2(STRB_WIDTH);
  localparam int MEM_AW     = $clog2(MEM_DEPTH);

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic [1:0]            wstate;
  logic [ID_WIDTH-1:0]   w_id;
  logic [ADDR_WIDTH-1:0] w_addr, w_addr_nx;
  logic [LEN_WIDTH-1:0]  w_len, w_cnt;
  logic [2:0]            w_size;
  logic [1:0]            w_burst;
  logic                  w_err;

  logic [0:0]            rstate;
  logic [ADDR_WIDTH-1:0] r_addr, r_addr_nx;
  logic [LEN_WIDTH-1:0]  r_len, r_cnt;
  logic [2:0]            r_size;
  logic [1:0]            r_burst;

  logic w_err_beat, r_err_first, r_err_next;

  // Termination is by beat count alone, so the W-channel framing fields carry no information here.
  logic unused_wframe;
  assign unused_wframe = ^{wid, wlast};

  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic [2:0] sz,
                                                      input logic [LEN_WIDTH-1:0] ln,
                                                      input logic [1:0] bt);
    logic [ADDR_WIDTH-1:0] step, mask;
    step = ADDR_WIDTH'(1) << sz;
    mask = (ADDR_WIDTH'(ln) + ADDR_WIDTH'(1)) * step - ADDR_WIDTH'(1);
    case (bt)
      2'b00:   return a;
      2'b10:   return (a & ~mask) | ((a + step) & mask);
      default: return a + step;
    endcase
  endfunction

  function automatic logic [MEM_AW-1:0] widx(input logic [ADDR_WIDTH-1:0] a);
    return a[LG_STRB +: MEM_AW];
  endfunction

`ifdef AXI_SLV_ERR_EN
  function automatic logic bad_beat(input logic [ADDR_WIDTH-1:0] a, input logic [2:0] sz);
    return (sz > 3'(LG_STRB)) || ((a >> (LG_STRB + MEM_AW)) != '0);
  endfunction
  assign w_err_beat  = bad_beat(w_addr, w_size);
  assign r_err_first = bad_beat(araddr, arsize);
  assign r_err_next  = bad_beat(r_addr_nx, r_size);
`else
  assign w_err_beat  = 1'b0;
  assign r_err_first = 1'b0;
  assign r_err_next  = 1'b0;
`endif

  assign w_addr_nx = next_addr(w_addr, w_size, w_len, w_burst);
  assign r_addr_nx = next_addr(r_addr, r_size, r_len, r_burst);

  assign awready = (wstate == W_IDLE) && aresetn;
  assign wready  = (wstate == W_DATA);
  assign bvalid  = (wstate == W_RESP);
  assign bid     = w_id;
  assign arready = (rstate == R_IDLE) && aresetn;
  assign rvalid  = (rstate == R_DATA);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wstate  <= W_IDLE;
      w_id    <= '0;
      w_addr  <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
      w_size  <= '0;
      w_burst <= '0;
      w_err   <= 1'b0;
      bresp   <= 2'b00;
    end else begin
      case (wstate)
        W_IDLE: if (awvalid) begin
          w_id    <= awid;
          w_addr  <= awaddr;
          w_len   <= awlen;
          w_size  <= awsize;
          w_burst <= awburst;
          w_cnt   <= '0;
          w_err   <= 1'b0;
          wstate  <= W_DATA;
        end
        W_DATA: if (wvalid) begin
          w_addr <= w_addr_nx;
          w_cnt  <= w_cnt + 1'b1;
          if (w_err_beat) w_err <= 1'b1;
          if (w_cnt == w_len) begin
            wstate <= W_RESP;
            bresp  <= (w_err || w_err_beat) ? 2'b10 : 2'b00;
          end
        end
        W_RESP: if (bready) wstate <= W_IDLE;
        default: wstate <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (wstate == W_DATA && wvalid && !w_err_beat) begin
      for (int i = 0; i < STRB_WIDTH; i++) begin
        if (wstrb[i]) mem[widx(w_addr)][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Reads sample mem with non-blocking semantics, so a same-cycle write to the word is not seen.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rstate  <= R_IDLE;
      r_addr  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_size  <= '0;
      r_burst <= '0;
      rid     <= '0;
      rdata   <= '0;
      rresp   <= 2'b00;
      rlast   <= 1'b0;
    end else begin
      case (rstate)
        R_IDLE: if (arvalid) begin
          r_addr  <= araddr;
          r_len   <= arlen;
          r_size  <= arsize;
          r_burst <= arburst;
          r_cnt   <= '0;
          rid     <= arid;
          rdata   <= r_err_first ? '0 : mem[widx(araddr)];
          rresp   <= r_err_first ? 2'b10 : 2'b00;
          rlast   <= (arlen == '0);
          rstate  <= R_DATA;
        end
        R_DATA: if (rready) begin
          if (rlast) begin
            rlast  <= 1'b0;
            rstate <= R_IDLE;
          end else begin
            r_addr <= r_addr_nx;
            r_cnt  <= r_cnt + 1'b1;
            rdata  <= r_err_next ? '0 : mem[widx(r_addr_nx)];
            rresp  <= r_err_next ? 2'b10 : 2'b00;
            rlast  <= ((r_cnt + 1'b1) == r_len);
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_slave_mem.sv
// Directed bench for axi_slave_mem: bursts, wrap, strobes, backpressure/IDs and out-of-range handling.
module tb_axi_slave_mem;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        awvalid, awready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        wvalid, wready;
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        bvalid, bready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        arvalid, arready;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid, rready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;

  localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10;
  localparam logic [31:0] VA = 32'hA0A0A0A0, VB = 32'hB1B1B1B1, VC = 32'hC2C2C2C2, VD = 32'hD3D3D3D3;

  int compared = 0;
  int mismatched = 0;

  logic [31:0] rd_data [16];
  logic [3:0]  rd_id   [16];
  logic        rd_last [16];
  logic [1:0]  rd_resp [16];
  int          rd_cycles, rd_stall_bad;
  logic        rd_lat_ok, w_bnext;
  logic [3:0]  b_id;
  logic [1:0]  b_resp;

  axi_slave_mem dut (
    .aclk(aclk), .aresetn(aresetn),
    .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr), .awlen(awlen),
    .awsize(awsize), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast)
  );

  always #5 aclk = ~aclk;

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_aw(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    while (!awready && n < 50) begin step(); n++; end
    if (!awready) begin
      compared++; mismatched++;
      $display("FAIL aw_timeout: awready=%b required 1", awready);
    end
    step();
    awvalid = 1'b0;
  endtask

  task automatic do_w(input logic [31:0] data, input logic [3:0] strb, input logic last);
    int n = 0;
    wdata = data; wstrb = strb; wlast = last; wid = awid; wvalid = 1'b1;
    while (!wready && n < 50) begin step(); n++; end
    if (!wready) begin
      compared++; mismatched++;
      $display("FAIL w_timeout: wready=%b required 1", wready);
    end
    step();
    wvalid = 1'b0;
    w_bnext = bvalid;
  endtask

  task automatic wait_b();
    int n = 0;
    bready = 1'b1;
    while (!bvalid && n < 50) begin step(); n++; end
    if (!bvalid) begin
      compared++; mismatched++;
      $display("FAIL b_timeout: bvalid=%b required 1", bvalid);
    end
    b_id = bid; b_resp = bresp;
    step();
    bready = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input logic toggle);
    int n = 0;
    int nb = 0;
    int cyc = 0;
    logic have_prev = 1'b0;
    logic [31:0] p_data;
    logic [3:0] p_id;
    logic p_last;
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    while (!arready && n < 50) begin step(); n++; end
    if (!arready) begin
      compared++; mismatched++;
      $display("FAIL ar_timeout: arready=%b required 1", arready);
    end
    step();
    arvalid = 1'b0;
    rd_lat_ok = rvalid;
    rd_stall_bad = 0;
    while (nb <= int'(len) && cyc < 200) begin
      rready = toggle ? (cyc % 2 == 0) : 1'b1;
      if (rvalid) begin
        if (have_prev && (rdata !== p_data || rid !== p_id || rlast !== p_last)) rd_stall_bad++;
        if (rready) begin
          rd_data[nb] = rdata; rd_id[nb] = rid; rd_last[nb] = rlast; rd_resp[nb] = rresp;
          nb++;
          have_prev = 1'b0;
        end else begin
          p_data = rdata; p_id = rid; p_last = rlast;
          have_prev = 1'b1;
        end
      end
      step();
      cyc++;
    end
    rready = 1'b0;
    rd_cycles = cyc;
    if (cyc >= 200) begin
      compared++; mismatched++;
      $display("FAIL r_timeout: beats=%0d required %0d", nb, int'(len) + 1);
    end
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    awvalid = 0; awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0;
    wvalid = 0; wid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;
    arvalid = 0; arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0; rready = 0;
    repeat (3) step();
    compared++;
    if ({awready, arready, wready, bvalid, rvalid, rlast} !== 6'b0) begin
      mismatched++;
      $display("FAIL reset_ctrl: got %b required 000000", {awready, arready, wready, bvalid, rvalid, rlast});
    end
    compared++;
    if ({bid, bresp, rid, rresp, rdata} !== 44'h0) begin
      mismatched++;
      $display("FAIL reset_data: got %h required 0", {bid, bresp, rid, rresp, rdata});
    end
    aresetn = 1'b1;
    #1;
    compared++;
    if ({awready, arready} !== 2'b11) begin
      mismatched++;
      $display("FAIL reset_release: awready/arready=%b required 11", {awready, arready});
    end
    step();
  endtask

  task automatic test_single();
    do_aw(4'd1, 32'h10, 4'd0, 3'd2, INCR);
    do_w(32'hDEADBEEF, 4'hF, 1'b1);
    compared++;
    if (w_bnext !== 1'b1) begin mismatched++; $display("FAIL single_b_latency: bvalid=%b required 1", w_bnext); end
    wait_b();
    compared++;
    if ({b_id, b_resp} !== {4'd1, 2'b00}) begin
      mismatched++; $display("FAIL single_bresp: bid/bresp=%h/%b required 1/00", b_id, b_resp);
    end
    do_read(4'd2, 32'h10, 4'd0, 3'd2, INCR, 1'b0);
    compared++;
    if (rd_lat_ok !== 1'b1) begin mismatched++; $display("FAIL single_r_latency: rvalid=%b required 1", rd_lat_ok); end
    compared++;
    if ({rd_data[0], rd_last[0], rd_id[0], rd_resp[0]} !== {32'hDEADBEEF, 1'b1, 4'd2, 2'b00}) begin
      mismatched++;
      $display("FAIL single_read: data=%h last=%b id=%h resp=%b required deadbeef 1 2 00",
               rd_data[0], rd_last[0], rd_id[0], rd_resp[0]);
    end
  endtask

  task automatic test_incr_burst();
    do_aw(4'd3, 32'h0, 4'd3, 3'd2, INCR);
    for (int i = 0; i < 4; i++) do_w(32'(i + 1), 4'hF, i == 3);
    wait_b();
    do_read(4'd3, 32'h0, 4'd3, 3'd2, INCR, 1'b0);
    compared++;
    if (rd_cycles !== 4) begin mismatched++; $display("FAIL incr_back_to_back: cycles=%0d required 4", rd_cycles); end
    for (int i = 0; i < 4; i++) begin
      compared++;
      if (rd_data[i] !== 32'(i + 1)) begin
        mismatched++; $display("FAIL incr_data[%0d]: got %h required %h", i, rd_data[i], i + 1);
      end
    end
    compared++;
    if ({rd_last[3], rd_last[2], rd_last[1], rd_last[0]} !== 4'b1000) begin
      mismatched++;
      $display("FAIL incr_rlast: got %b required 1000", {rd_last[3], rd_last[2], rd_last[1], rd_last[0]});
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_incr [4];
    logic [31:0] exp_wrap [4];
    exp_incr = '{VC, VD, VA, VB};
    exp_wrap = '{VA, VB, VC, VD};
    do_aw(4'd4, 32'h08, 4'd3, 3'd2, WRAP);
    do_w(VA, 4'hF, 1'b0); do_w(VB, 4'hF, 1'b0); do_w(VC, 4'hF, 1'b0); do_w(VD, 4'hF, 1'b1);
    wait_b();
    do_read(4'd4, 32'h0, 4'd3, 3'd2, INCR, 1'b0);
    for (int i = 0; i < 4; i++) begin
      compared++;
      if (rd_data[i] !== exp_incr[i]) begin
        mismatched++; $display("FAIL wrap_layout[%0d]: got %h required %h", i, rd_data[i], exp_incr[i]);
      end
    end
    do_read(4'd4, 32'h08, 4'd3, 3'd2, WRAP, 1'b0);
    for (int i = 0; i < 4; i++) begin
      compared++;
      if (rd_data[i] !== exp_wrap[i]) begin
        mismatched++; $display("FAIL wrap_read[%0d]: got %h required %h", i, rd_data[i], exp_wrap[i]);
      end
    end
  endtask

  task automatic test_strobe();
    do_aw(4'd5, 32'h20, 4'd0, 3'd2, INCR); do_w(32'h11223344, 4'hF, 1'b1); wait_b();
    do_aw(4'd5, 32'h20, 4'd0, 3'd2, INCR); do_w(32'hAABBCCDD, 4'b0101, 1'b1); wait_b();
    do_read(4'd5, 32'h20, 4'd0, 3'd2, INCR, 1'b0);
    compared++;
    if (rd_data[0] !== 32'h11BB33DD) begin
      mismatched++; $display("FAIL strobe_merge: got %h required 11bb33dd", rd_data[0]);
    end
  endtask

  task automatic test_fixed();
    do_aw(4'd6, 32'h30, 4'd1, 3'd2, FIXED);
    do_w(32'h12345678, 4'hF, 1'b0); do_w(32'h9ABCDEF0, 4'hF, 1'b1); wait_b();
    do_read(4'd6, 32'h34, 4'd0, 3'd2, INCR, 1'b0);
    compared++;
    if (rd_data[0] === 32'h12345678) begin
      mismatched++; $display("FAIL fixed_no_advance: word 0x34 got %h required not 12345678", rd_data[0]);
    end
    do_read(4'd6, 32'h30, 4'd1, 3'd2, FIXED, 1'b0);
    compared++;
    if ({rd_data[0], rd_data[1]} !== {32'h9ABCDEF0, 32'h9ABCDEF0}) begin
      mismatched++; $display("FAIL fixed_read: got %h %h required 9abcdef0 x2", rd_data[0], rd_data[1]);
    end
  endtask

  task automatic test_backpressure();
    do_aw(4'd7, 32'h40, 4'd2, 3'd2, INCR);
    do_w(32'h100, 4'hF, 1'b0); do_w(32'h101, 4'hF, 1'b0); do_w(32'h102, 4'hF, 1'b1);
    wait_b();
    fork
      do_read(4'd5, 32'h40, 4'd2, 3'd2, INCR, 1'b1);
      begin
        do_aw(4'd9, 32'h80, 4'd0, 3'd2, INCR);
        do_w(32'h99, 4'hF, 1'b1);
        wait_b();
      end
    join
    compared++;
    if (rd_stall_bad !== 0) begin
      mismatched++; $display("FAIL bp_stable: changes while stalled=%0d required 0", rd_stall_bad);
    end
    for (int i = 0; i < 3; i++) begin
      compared++;
      if ({rd_data[i], rd_id[i]} !== {32'(32'h100 + i), 4'd5}) begin
        mismatched++;
        $display("FAIL bp_beat[%0d]: data=%h id=%h required %h 5", i, rd_data[i], rd_id[i], 32'h100 + i);
      end
    end
    compared++;
    if (rd_last[2] !== 1'b1) begin mismatched++; $display("FAIL bp_rlast: got %b required 1", rd_last[2]); end
    compared++;
    if (b_id !== 4'd9) begin mismatched++; $display("FAIL concurrent_bid: got %h required 9", b_id); end
  endtask

`ifdef AXI_SLV_ERR_EN
  task automatic test_out_of_range();
    do_read(4'd1, 32'h400, 4'd0, 3'd2, INCR, 1'b0);
    compared++;
    if ({rd_resp[0], rd_data[0]} !== {2'b10, 32'h0}) begin
      mismatched++; $display("FAIL err_read: resp=%b data=%h required 10 0", rd_resp[0], rd_data[0]);
    end
    do_aw(4'd2, 32'h400, 4'd0, 3'd2, INCR); do_w(32'h55, 4'hF, 1'b1); wait_b();
    compared++;
    if (b_resp !== 2'b10) begin mismatched++; $display("FAIL err_bresp: got %b required 10", b_resp); end
    do_read(4'd1, 32'h0, 4'd0, 3'd2, INCR, 1'b0);
    compared++;
    if (rd_data[0] !== VC) begin mismatched++; $display("FAIL err_mem_intact: got %h required %h", rd_data[0], VC); end
  endtask
`else
  task automatic test_out_of_range();
    do_aw(4'd2, 32'h450, 4'd0, 3'd2, INCR); do_w(32'hCAFEF00D, 4'hF, 1'b1); wait_b();
    compared++;
    if (b_resp !== 2'b00) begin mismatched++; $display("FAIL oob_bresp: got %b required 00", b_resp); end
    do_read(4'd1, 32'h50, 4'd0, 3'd2, INCR, 1'b0);
    compared++;
    if ({rd_resp[0], rd_data[0]} !== {2'b00, 32'hCAFEF00D}) begin
      mismatched++; $display("FAIL oob_wrap: resp=%b data=%h required 00 cafef00d", rd_resp[0], rd_data[0]);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_incr_burst();
    test_wrap();
    test_strobe();
    test_fixed();
    test_backpressure();
    test_out_of_range();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/axi_slave_mem.md
Name: axi_slave_mem

Overview:
- Synthesisable, parametrised AXI3 slave with internal word-addressed memory.
- Fully independent write path (AW/W/B) and read path (AR/R).
- Supports FIXED, INCR and WRAP bursts, byte strobes, narrow sizes, configurable ID width and 2-bit response codes.
- Used as the DUT-side memory target behind the AXI interface in block and system benches, replacing behavioural responders.

Parameters:
- ADDR_WIDTH, 32, byte address width of AW/AR channels
- DATA_WIDTH, 32, data bus width; must be 32, 64 or 128; STRB_WIDTH = DATA_WIDTH/8 is derived, not a parameter
- ID_WIDTH, 4, width of awid/wid/bid/arid/rid
- LEN_WIDTH, 4, burst length field width (beats = len+1)
- MEM_DEPTH, 256, memory depth in DATA_WIDTH words; power of two

Ports:
- aclk  in  1  clock, all logic on rising edge
- aresetn  in  1  asynchronous active-low reset
- awvalid/awready  in/out  1  write address handshake
- awid/awaddr/awlen  in  ID_WIDTH/ADDR_WIDTH/LEN_WIDTH  write address attributes
- awsize/awburst  in  3/2  write address attributes
- wvalid/wready  in/out  1  write data handshake
- wid/wdata/wstrb/wlast  in  ID_WIDTH/DATA_WIDTH/STRB_WIDTH/1  write data beat
- bvalid/bready  out/in  1  write response handshake
- bid/bresp  out  ID_WIDTH/2  write response ID and code
- arvalid/arready  in/out  1  read address handshake
- arid/araddr/arlen/arsize/arburst  in  ID_WIDTH/ADDR_WIDTH/LEN_WIDTH/3/2  read address attributes
- rvalid/rready  out/in  1  read data handshake
- rid/rdata/rresp/rlast  out  ID_WIDTH/DATA_WIDTH/2/1  read data beat

Behaviour:
- Reset: write FSM to W_IDLE, read FSM to R_IDLE. bvalid, rvalid and rlast = 0; bid, bresp, rid, rresp and rdata = 0. Readies are 0 while aresetn = 0. Memory contents are not reset.
- Reset mid-burst abandons the burst immediately; any beats already written stay in memory.
- Readies are decoded from state (not registered): awready = (W_IDLE & aresetn); wready = W_DATA; arready = (R_IDLE & aresetn).
- Write FSM:
  - W_IDLE: on awvalid&awready, latch id/addr/len/size/burst, clear beat counter, go to W_DATA.
  - W_DATA: each wvalid&wready writes the byte lanes whose wstrb bit is set at word index (addr >> log2(STRB_WIDTH)) mod MEM_DEPTH, then advances the address. When beat counter == len, go to W_RESP. wlast and wid are ignored for termination; termination is by count only.
  - W_RESP: bvalid = 1, bid = latched id, bresp = 2'b00. Hold until bready, then return to W_IDLE. bvalid rises the cycle after the last W beat.
- Read FSM:
  - R_IDLE: on arvalid&arready, latch attributes and register rdata for the first beat. rvalid = 1 in the next cycle (1-cycle latency).
  - R_DATA: rid = latched id, rresp = 2'b00, rlast = (beat counter == len). On rvalid&rready of a non-last beat, advance the address and register the next word with no bubble. On the last beat, return to R_IDLE; arready is 1 in the following cycle.
  - rdata, rid, rlast and rresp are stable while rvalid & !rready.
- Address update, with step = 1 << size:
  - FIXED (00): address unchanged.
  - INCR (01): address + step.
  - WRAP (10): wrap boundary = (len+1)*step. Address = (addr & ~(boundary-1)) | ((addr + step) & (boundary-1)).
  - Reserved (11): treated as INCR.
  - Arithmetic is ADDR_WIDTH bits with natural wrap at 2^ADDR_WIDTH.
- Narrow transfers: lane selection is by wstrb only on writes. Reads return the full word; the master selects lanes.
- Same-cycle read and write to the same word: the read register captures pre-write data.
- AW/AR accepted in the same cycle proceed concurrently; there is no arbitration.

Optional Feature:
- Macro AXI_SLV_ERR_EN.
- When defined, a burst is flagged as error if:
  - size > log2(STRB_WIDTH), or
  - any beat address is ≥ MEM_DEPTH*STRB_WIDTH.
- Error handling when defined:
  - Erroring write beats are not written to memory.
  - bresp = 2'b10 (SLVERR) if any beat errored.
  - Erroring read beats return rdata = 0 and rresp = 2'b10, set per beat.
- When undefined: responses are always 2'b00 and out-of-range addresses wrap modulo MEM_DEPTH.

Test Plan:
- Single INCR write: awaddr=0x10, len=0, wdata=0xDEADBEEF, wstrb=4'hF; then read 0x10. Expect bresp=00 one cycle after the W beat, rdata=0xDEADBEEF, rlast=1.
- INCR len=3 at 0x0, data 1..4, rready held 1. Expect 4 back-to-back R beats 1,2,3,4 and rlast only on the 4th beat.
- WRAP len=3, size=2, at 0x08 writing A,B,C,D. Expect words at 0x08,0x0C,0x00,0x04 = A,B,C,D.
- Strobe merge: write 0x11223344 to 0x20, then write 0xAABBCCDD with wstrb=4'b0101. Expect read 0x11BB33DD.
- Backpressure and IDs: rready toggled 1/0 during a len=2 read with arid=5. Expect rdata stable while stalled and rid=5 on every beat. A concurrent write with awid=9 returns bid=9.
- With AXI_SLV_ERR_EN: read at MEM_DEPTH*4. Expect rresp=10 and rdata=0. A write there returns bresp=10 and memory is unchanged.
